// File: rtl/jk_cmd_seq.sv
// rtl/jk_cmd_seq.sv - command sequencer driving the J/K/EN inputs of an FFJK flip-flop
//
// Buffers {op, rep} commands in a DEPTH-entry FIFO and plays each one onto
// registered J/K/EN for exactly rep+1 clock cycles, back-to-back while the
// FIFO holds further commands.
//
// Optional feature macro: JK_SEQ_CHECK_EN adds an expected-Q model of the
// downstream flip-flop and a sticky mismatch flag.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_reset      asynchronous active-high reset, clears all state
//   i_cmd_valid  command present
//   o_cmd_ready  FIFO can accept (occupancy < DEPTH)
//   i_cmd_op     00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//   i_cmd_rep    command drives EN for i_cmd_rep+1 cycles
//   o_j/o_k/o_en registered drive to the flip-flop
//   o_busy       running a command or FIFO non-empty
//   i_q_fb       flip-flop Q feedback            (JK_SEQ_CHECK_EN only)
//   o_mismatch   sticky expected-Q check failure (JK_SEQ_CHECK_EN only)

module jk_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [CNT_W-1:0] i_cmd_rep,
    output logic             o_j,
    output logic             o_k,
    output logic             o_en,
    output logic             o_busy
`ifdef JK_SEQ_CHECK_EN
    ,
    input  logic             i_q_fb,
    output logic             o_mismatch
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 2 + CNT_W;

    localparam logic [AW-1:0]    PTR_ONE = 1;
    localparam logic [AW:0]      CNT_ONE = 1;
    localparam logic [CNT_W-1:0] REM_ONE = 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_rem;
    logic             r_j;
    logic             r_k;
    logic             r_en;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [EW-1:0]    w_head;

    // DEPTH is a power of two and occupancy never exceeds it, so the MSB of
    // the count alone flags a full FIFO.
    assign w_full  = r_count[AW];
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // Both decisions use pre-edge occupancy: a full FIFO refuses a push even
    // while popping, and an entry written this edge is not popped until the next.
    assign w_push = i_cmd_valid && !w_full;
    assign w_pop  = !w_empty && ((r_state == S_IDLE) || (r_rem == '0));

    assign o_cmd_ready = !w_full;
    assign o_busy      = (r_state == S_RUN) || !w_empty;
    assign o_j         = r_j;
    assign o_k         = r_k;
    assign o_en        = r_en;

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_cmd_op, i_cmd_rep};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Op bits map directly onto the pins: J = op[1], K = op[0].
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_en    <= 1'b0;
        end else if (w_pop) begin
            r_state <= S_RUN;
            r_rem   <= w_head[CNT_W-1:0];
            r_j     <= w_head[EW-1];
            r_k     <= w_head[EW-2];
            r_en    <= 1'b1;
        end else if (r_state == S_RUN) begin
            if (r_rem != '0) begin
                r_rem <= r_rem - REM_ONE;
            end else begin
                r_state <= S_IDLE;
                r_j     <= 1'b0;
                r_k     <= 1'b0;
                r_en    <= 1'b0;
            end
        end
    end

`ifdef JK_SEQ_CHECK_EN
    logic r_exp_q;
    logic r_exp_valid;
    logic r_mismatch;

    assign o_mismatch = r_mismatch;

    // Mirrors the flip-flop: it samples the same registered J/K/EN on the
    // same edge, so pre-edge r_exp_q is directly comparable to i_q_fb.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_exp_q     <= 1'b0;
            r_exp_valid <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            if (r_exp_valid && (i_q_fb != r_exp_q)) begin
                r_mismatch <= 1'b1;
            end
            if (r_en) begin
                case ({r_j, r_k})
                    2'b01: begin
                        r_exp_q     <= 1'b0;
                        r_exp_valid <= 1'b1;
                    end
                    2'b10: begin
                        r_exp_q     <= 1'b1;
                        r_exp_valid <= 1'b1;
                    end
                    2'b11:   r_exp_q <= ~r_exp_q;
                    default: r_exp_q <= r_exp_q;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb/tb_jk_cmd_seq.sv - scoreboard bench for jk_cmd_seq

module tb_jk_cmd_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_rep;
    logic       cmd_ready;
    logic       j;
    logic       k;
    logic       en;
    logic       busy;
`ifdef JK_SEQ_CHECK_EN
    logic       q_fb;
    logic       mismatch;
    logic       ff_q;
    logic       inv;
`endif

    always #5 clk = ~clk;

    jk_cmd_seq #(.DEPTH(4), .CNT_W(4)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_rep   (cmd_rep),
        .o_j         (j),
        .o_k         (k),
        .o_en        (en),
        .o_busy      (busy)
`ifdef JK_SEQ_CHECK_EN
        ,
        .i_q_fb      (q_fb),
        .o_mismatch  (mismatch)
`endif
    );

`ifdef JK_SEQ_CHECK_EN
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_q <= 1'b0;
        end else if (en) begin
            case ({j, k})
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end
    assign q_fb = ff_q ^ inv;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] sb_q[$];
    int run_cnt  = 0;
    int last_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every EN-high cycle must match the next expected {J,K,EN}; idle cycles keep J/K low.
    always @(negedge clk) begin
        if (reset) begin
            run_cnt = 0;
        end else if (en) begin
            run_cnt++;
            if (sb_q.size() == 0) check("sb_unexpected_en", {j, k, en}, 3'b000);
            else                  check("sb_jken", {j, k, en}, sb_q.pop_front());
        end else begin
            check("idle_jk", {j, k}, 2'b00);
            if (run_cnt != 0) begin
                last_run = run_cnt;
                run_cnt  = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [1:0] op, input logic [3:0] rep);
        int tries = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rep   = rep;
        while (!cmd_ready && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (!cmd_ready) check("push_timeout", cmd_ready, 1);
        @(posedge clk);
        for (int i = 0; i <= int'(rep); i++) sb_q.push_back({op, 1'b1});
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int accepts;
        int refused;
        int guard;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_rep   = 4'd0;
`ifdef JK_SEQ_CHECK_EN
        inv = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_jken", {j, k, en}, 3'b000);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);

        // SET rep=0: one-cycle pulse one edge after acceptance
        push(2'b10, 4'd0);
        check("lat_pre_en", {j, k, en}, 3'b000);
        check("lat_pre_busy", busy, 1);
        @(negedge clk);
        check("lat_first", {j, k, en}, 3'b101);
        @(negedge clk);
        check("pulse_end", {j, k, en}, 3'b000);
        check("busy_drop", busy, 0);
        @(negedge clk);
        check("pulse_len", last_run, 1);

        // RESET rep=3 then TOGGLE rep=1: six contiguous EN cycles
        push(2'b01, 4'd3);
        push(2'b11, 4'd1);
        wait_idle(50);
        check("b2b_len", last_run, 6);

        // Hold valid with HOLD rep=15: fifth accept fills the FIFO, sixth waits for a pop
        accepts   = 0;
        refused   = 0;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_rep   = 4'd15;
        while (accepts < 6 && guard < 200) begin
            guard++;
            if (cmd_ready) begin
                @(posedge clk);
                accepts++;
                for (int i = 0; i < 16; i++) sb_q.push_back(3'b001);
                @(negedge clk);
                if (accepts == 5) check("full_ready", cmd_ready, 0);
            end else begin
                refused++;
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        check("full_accepts", accepts, 6);
        check("full_refused", refused, 13);
        wait_idle(200);
        check("full_len", last_run, 96);

        // Asynchronous reset mid-command with two queued commands
        push(2'b10, 4'd7);
        push(2'b01, 4'd0);
        push(2'b11, 4'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_jken", {j, k, en}, 3'b000);
        check("arst_busy", busy, 0);
        check("arst_ready", cmd_ready, 1);
`ifdef JK_SEQ_CHECK_EN
        check("arst_mismatch", mismatch, 0);
`endif
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("no_replay_busy", busy, 0);

        // Maximum repeat count: 16 cycles, no counter wrap
        push(2'b10, 4'd15);
        wait_idle(100);
        check("max_rep_len", last_run, 16);

`ifdef JK_SEQ_CHECK_EN
        push(2'b10, 4'd0);
        push(2'b11, 4'd0);
        push(2'b11, 4'd0);
        push(2'b11, 4'd0);
        push(2'b01, 4'd0);
        wait_idle(50);
        check("chk_clean", mismatch, 0);
        push(2'b10, 4'd0);
        wait_idle(20);
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        @(negedge clk);
        check("chk_set", mismatch, 1);
        repeat (3) @(negedge clk);
        check("chk_sticky", mismatch, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("chk_rst", mismatch, 0);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
